// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence path: the serializer state
// encoding and the counter width that the detector-side counters reuse.
package seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } seq_state_e;

  localparam int SEQ_CNT_W = 16;

endpackage : seq_pkg

// File: rtl/seq_hold_reg.sv
// One-entry holding buffer in front of the serializer's shifter.
// A word is captured on in_valid_i & in_ready_o; pop_i releases it.
module seq_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  input  logic             pop_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q;
  logic             full_d;
  logic             push;
  logic [WIDTH-1:0] data_q;

  // The buffer can take a word whenever it is empty.
  assign in_ready_o = ~full_q;
  assign push       = in_valid_i & in_ready_o;

  // Occupancy: a push fills the entry, a pop empties it, a push wins on a tie.
  always_comb begin
    full_d = push | (full_q & ~pop_i);
  end

  // Occupancy flag register.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  // Payload register.
  // NOTE: the payload is deliberately not reset; it is only ever read while
  // full_q is set, so clearing it would cost reset routing for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q <= in_data_i;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule : seq_hold_reg

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding the sequence detector. Words arrive on a
// valid/ready handshake and leave one bit per clock; a one-word holding
// buffer lets consecutive words stream without an idle gap.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 data_out,
  output logic                 dout_valid,
  output logic                 last_bit,
  output logic                 busy,
  output logic [SEQ_CNT_W-1:0] word_cnt
);

  localparam int          CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  seq_state_e           state_q,      state_d;
  logic [CW-1:0]        bit_cnt_q,    bit_cnt_d;
  logic [WIDTH-1:0]     sh_q,         sh_d;
  logic                 data_out_q,   data_out_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 last_bit_q,   last_bit_d;
  logic [SEQ_CNT_W-1:0] word_cnt_q,   word_cnt_d;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             load_slot;
  logic             transfer;
  logic             do_load;
  logic [WIDTH-1:0] load_word;

  // Bit that leaves the wire first for a given word.
  function automatic logic first_of(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with its first-out bit consumed, so first_of() yields the next one.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // The shifter can accept a new word when empty or on its final bit.
  assign load_slot = (state_q == ST_IDLE) || (bit_cnt_q == LAST_IDX);
  assign transfer  = din_valid & din_ready & ~rst;
  assign do_load   = load_slot & (hold_full | transfer);
  assign load_word = hold_full ? hold_data : din;

  seq_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    // A word arriving on a free load slot bypasses the buffer.
    .in_valid_i (din_valid & ~rst & ~(load_slot & ~hold_full)),
    .in_data_i  (din),
    .in_ready_o (din_ready),
    .pop_i      (load_slot & hold_full),
    .full_o     (hold_full),
    .data_o     (hold_data)
  );

  // Next-state, shifter and output-register logic.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sh_d         = sh_q;
    data_out_d   = data_out_q;
    dout_valid_d = dout_valid_q;
    last_bit_d   = last_bit_q;
    word_cnt_d   = word_cnt_q + SEQ_CNT_W'(last_bit_q);

    if (load_slot) begin
      bit_cnt_d = '0;
      if (do_load) begin
        state_d      = ST_SHIFT;
        data_out_d   = first_of(load_word);
        sh_d         = advance(load_word);
        dout_valid_d = 1'b1;
        last_bit_d   = 1'b0;
      end else begin
        state_d      = ST_IDLE;
        data_out_d   = IDLE_BIT;
        dout_valid_d = 1'b0;
        last_bit_d   = 1'b0;
      end
    end else begin
      bit_cnt_d  = bit_cnt_q + 1'b1;
      data_out_d = first_of(sh_q);
      sh_d       = advance(sh_q);
      last_bit_d = (bit_cnt_q == PRE_LAST);
    end
  end

  // State, counters and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      data_out_q   <= IDLE_BIT;
      dout_valid_q <= 1'b0;
      last_bit_q   <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      dout_valid_q <= dout_valid_d;
      last_bit_q   <= last_bit_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  // Shift register carries payload only; its content is ignored in IDLE.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign data_out   = data_out_q;
  assign dout_valid = dout_valid_q;
  assign last_bit   = last_bit_q;
  assign word_cnt   = word_cnt_q;
  assign busy       = (state_q == ST_SHIFT) | hold_full;

endmodule : seq_serializer

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: one default instance (MSB first,
// idle bit 0) and one LSB-first instance with idle bit 1.
module tb_seq_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready, data_out, dout_valid, last_bit, busy;
  logic [15:0] word_cnt;

  logic [7:0]  din2 = '0;
  logic        din_valid2 = 1'b0;
  logic        din_ready2, data_out2, dout_valid2, last_bit2, busy2;
  logic [15:0] word_cnt2;

  int total = 0;
  int bad   = 0;
  int exp_wc = 0;

  // Stream capture shared by the multi-word scenarios.
  logic [7:0] words [3];
  bit         got_q [$];
  bit         lb_q  [$];
  int         first_v, last_v, ready_low, sent;
  int         xfer_cyc [3];

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .data_out(data_out), .dout_valid(dout_valid),
    .last_bit(last_bit), .busy(busy), .word_cnt(word_cnt)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .din(din2), .din_valid(din_valid2),
    .din_ready(din_ready2), .data_out(data_out2), .dout_valid(dout_valid2),
    .last_bit(last_bit2), .busy(busy2), .word_cnt(word_cnt2)
  );

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer words[0..nw-1] back to back and record the serial stream.
  task automatic run_stream(input int nw);
    bit xfer;
    got_q.delete();
    lb_q.delete();
    first_v = -1; last_v = -1; ready_low = 0; sent = 0;
    din = words[0];
    din_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (dout_valid) begin
        got_q.push_back(data_out);
        lb_q.push_back(last_bit);
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (!din_ready) ready_low++;
      xfer = din_valid && din_ready;
      if (xfer) xfer_cyc[sent] = c;
      step();
      if (xfer) begin
        sent++;
        if (sent < nw) din = words[sent];
        else din_valid = 1'b0;
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 8'hF4; din_valid = 1'b1;
    step(); step();
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", din_ready); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dvalid: got %b want 0", dout_valid); end
    total++; if (data_out !== 1'b0) begin bad++; $display("FAIL reset_data: got %b want 0", data_out); end
    total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL reset_wcnt: got %0d want 0", word_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (data_out2 !== 1'b1) begin bad++; $display("FAIL reset_idle_bit1: got %b want 1", data_out2); end
    rst = 1'b0; din_valid = 1'b0;
    step();
    // A valid held during reset must not have been taken.
    total++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_no_take: got dv=%b busy=%b want 0 0", dout_valid, busy); end
  endtask

  task automatic test_reset_mid();
    din = 8'hF4; din_valid = 1'b1;
    step();                      // edge N: word loads from IDLE
    din = 8'h0B;
    step();                      // edge N+1: second word goes into hold
    din_valid = 1'b0;
    step(); step(); step();      // now presenting bit index 4 of 11110100
    total++; if (dout_valid !== 1'b1 || data_out !== 1'b0) begin bad++; $display("FAIL mid_bit4: got dv=%b d=%b want 1 0", dout_valid, data_out); end
    total++; if (din_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL mid_held: got rdy=%b busy=%b want 0 1", din_ready, busy); end
    rst = 1'b1; din_valid = 1'b1;
    step();
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_dvalid: got %b want 0", dout_valid); end
    total++; if (busy !== 1'b0 || din_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_hold: got busy=%b rdy=%b want 0 1", busy, din_ready); end
    total++; if (word_cnt !== 16'(exp_wc) || last_bit !== 1'b0) begin bad++; $display("FAIL mid_rst_wcnt: got %0d lb=%b want %0d 0", word_cnt, last_bit, exp_wc); end
    rst = 1'b0; din_valid = 1'b0;
    step();
    total++; if (dout_valid !== 1'b0 || word_cnt !== 16'(exp_wc)) begin bad++; $display("FAIL mid_after: got dv=%b wc=%0d want 0 %0d", dout_valid, word_cnt, exp_wc); end
  endtask

  task automatic test_single();
    logic [7:0] bits;
    bits = 8'b1111_0100;
    din = 8'hF4; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dout_valid !== 1'b1 || data_out !== bits[7-i] || last_bit !== (i == 7)) begin
        bad++; $display("FAIL single_bit%0d: got dv=%b d=%b lb=%b want 1 %b %b", i, dout_valid, data_out, last_bit, bits[7-i], (i == 7));
      end
      step();
    end
    exp_wc = exp_wc + 1;
    total++; if (dout_valid !== 1'b0 || busy !== 1'b0 || last_bit !== 1'b0 || data_out !== 1'b0) begin bad++; $display("FAIL single_idle: got dv=%b busy=%b lb=%b d=%b want 0 0 0 0", dout_valid, busy, last_bit, data_out); end
    total++; if (word_cnt !== 16'(exp_wc)) begin bad++; $display("FAIL single_wcnt: got %0d want %0d", word_cnt, exp_wc); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_bits;
    exp_bits = 16'b1111_0100_0000_1011;
    words[0] = 8'hF4; words[1] = 8'h0B; words[2] = 8'h00;
    run_stream(2);
    exp_wc = exp_wc + 2;
    total++; if (sent !== 2) begin bad++; $display("FAIL b2b_sent: got %0d want 2", sent); end
    total++; if (got_q.size() !== 16) begin bad++; $display("FAIL b2b_nbits: got %0d want 16", got_q.size()); end
    total++; if (last_v - first_v + 1 !== 16) begin bad++; $display("FAIL b2b_gapless: got span %0d want 16", last_v - first_v + 1); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_bits[15-i] || lb_q[i] !== ((i % 8) == 7)) begin
        bad++; $display("FAIL b2b_bit%0d: got d=%b lb=%b want %b %b", i, got_q[i], lb_q[i], exp_bits[15-i], ((i % 8) == 7));
      end
    end
    // Second word sits in hold from edge N+1 to N+8: seven not-ready cycles.
    total++; if (ready_low !== 7) begin bad++; $display("FAIL b2b_ready_low: got %0d want 7", ready_low); end
    total++; if (word_cnt !== 16'(exp_wc)) begin bad++; $display("FAIL b2b_wcnt: got %0d want %0d", word_cnt, exp_wc); end
  endtask

  task automatic test_hold_stall();
    logic [23:0] exp_bits;
    exp_bits = 24'b1111_0100_0000_1011_1010_0101;
    words[0] = 8'hF4; words[1] = 8'h0B; words[2] = 8'hA5;
    run_stream(3);
    exp_wc = exp_wc + 3;
    total++; if (sent !== 3) begin bad++; $display("FAIL stall_sent: got %0d want 3", sent); end
    total++; if (xfer_cyc[1] - xfer_cyc[0] !== 1) begin bad++; $display("FAIL stall_xfer2: got +%0d want +1", xfer_cyc[1] - xfer_cyc[0]); end
    // Word 1 last bit is in the cycle ending at edge N+8, which drains hold;
    // ready reappears after that edge, so word 3 transfers at edge N+9.
    total++; if (xfer_cyc[2] - xfer_cyc[0] !== 9) begin bad++; $display("FAIL stall_xfer3: got +%0d want +9", xfer_cyc[2] - xfer_cyc[0]); end
    total++; if (got_q.size() !== 24) begin bad++; $display("FAIL stall_nbits: got %0d want 24", got_q.size()); end
    total++; if (last_v - first_v + 1 !== 24) begin bad++; $display("FAIL stall_gapless: got span %0d want 24", last_v - first_v + 1); end
    for (int i = 0; i < 24 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_bits[23-i] || lb_q[i] !== ((i % 8) == 7)) begin
        bad++; $display("FAIL stall_bit%0d: got d=%b lb=%b want %b %b", i, got_q[i], lb_q[i], exp_bits[23-i], ((i % 8) == 7));
      end
    end
    total++; if (ready_low !== 14) begin bad++; $display("FAIL stall_ready_low: got %0d want 14", ready_low); end
    total++; if (word_cnt !== 16'(exp_wc)) begin bad++; $display("FAIL stall_wcnt: got %0d want %0d", word_cnt, exp_wc); end
  endtask

  task automatic test_params();
    logic [7:0] bits;
    bits = 8'b0010_1111;   // F4 sent LSB first: 0,0,1,0,1,1,1,1
    total++; if (data_out2 !== 1'b1 || dout_valid2 !== 1'b0) begin bad++; $display("FAIL lsb_idle_pre: got d=%b dv=%b want 1 0", data_out2, dout_valid2); end
    din2 = 8'hF4; din_valid2 = 1'b1;
    step();
    din_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dout_valid2 !== 1'b1 || data_out2 !== bits[7-i] || last_bit2 !== (i == 7)) begin
        bad++; $display("FAIL lsb_bit%0d: got dv=%b d=%b lb=%b want 1 %b %b", i, dout_valid2, data_out2, last_bit2, bits[7-i], (i == 7));
      end
      step();
    end
    total++; if (data_out2 !== 1'b1 || dout_valid2 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL lsb_idle_post: got d=%b dv=%b busy=%b want 1 0 0", data_out2, dout_valid2, busy2); end
    total++; if (word_cnt2 !== 16'd1) begin bad++; $display("FAIL lsb_wcnt: got %0d want 1", word_cnt2); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reset_mid();
    test_single();
    test_back_to_back();
    test_hold_stall();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_serializer
